// File: rtl/adder_share_arb.sv
// adder_share_arb
//   One WIDTH-bit adder shared by NREQ requesters under round-robin
//   arbitration. Requesters hand over operand pairs with a valid/ready
//   handshake. The granted pair is summed into a WIDTH+1 bit result, which
//   is returned tagged with the requester index over a valid/ready
//   response port. Each operation takes at least three cycles:
//   IDLE (grant), CALC (add), RESP (handshake).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : [NREQ]        per-requester operand valid
//   req_ready  : [NREQ]        per-requester accept, one-hot or zero
//   req_a      : [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : [NREQ*WIDTH]  operand B, same slicing
//   resp_valid : result available
//   resp_ready : consumer accepts result
//   resp_sum   : [WIDTH+1]     zero-extended a + b, carry in MSB
//   resp_id    : [IDW]         index of the requester that produced resp_sum
//   busy       : high whenever the FSM is not in IDLE
module adder_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH:0]        resp_sum,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_next;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [IDW-1:0]   id_p0;

  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // candidate down to rr_ptr itself so the nearest valid requester is the
  // last one written and therefore wins. cand carries one extra bit so the
  // wrap works for NREQ values that are not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  assign rr_ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // The accept is gated by rst_n so no requester sees a handshake while the
  // block is being reset.
  assign req_ready = (rst_n && (state == IDLE) && win_found)
                   ? (NREQ'(1) << win_id) : '0;

  assign busy = (state != IDLE);

  // Control FSM and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            rr_ptr <= rr_ptr_next;
            state  <= CALC;
          end
        end
        CALC: begin
          resp_sum   <= {1'b0, a_p0} + {1'b0, b_p0};
          resp_id    <= id_p0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: operand capture at grant time. These are pure data and need
  // no reset; they are only consumed in CALC, which is only reached from a
  // grant.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && win_found) begin
      a_p0  <= req_a[win_id*WIDTH +: WIDTH];
      b_p0  <= req_b[win_id*WIDTH +: WIDTH];
      id_p0 <= win_id;
    end
  end

endmodule
